// File: rtl/nand_pkg.sv
// Shared definitions for the NAND controller datapath blocks.
//   burst_state_t : state encoding of the burst sequencer
//   DIR_READ/DIR_WRITE : burst direction encoding carried on 'dir'
//   DEF_DATA_W/DEF_LEN_W : default NAND word width and burst length/address width
package nand_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 14;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        STORE,
        NEXT,
        FIN
    } burst_state_t;

endpackage

// File: rtl/io_burst_sequencer.sv
// Burst sequencer between the command FSM / page buffer and the NAND data IO unit.
// One accepted start runs 'length' word transfers: writes fetch each word from the
// page buffer and hand it to the IO unit, reads take each word from the IO unit and
// store it into the page buffer. Each word uses the IO unit's activate/busy handshake.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, dir, length  : burst request (sampled only in IDLE)
//   busy, done, error   : burst status (done is a one-cycle pulse, error is sticky)
//   buf_addr/re/rdata   : page buffer read port (1-cycle read latency)
//   buf_we/wdata        : page buffer write port (shares buf_addr)
//   io_activate, io_wdata, io_rdata, io_busy : IO unit word handshake and data
module io_burst_sequencer
    import nand_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int ACT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  buf_addr,
    output logic              buf_re,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              buf_we,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              io_activate,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_busy
);

    localparam int TMO_W = (ACT_TIMEOUT > 1) ? $clog2(ACT_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACT_TIMEOUT - 1);

    burst_state_t      state;
    burst_state_t      state_nxt;
    logic              dir_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              error_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_word;
    logic              tmo_expired;

    // length is never 0 once NEXT is reached, so length-1 cannot wrap here
    assign last_word   = (word_cnt == (len_q - LEN_W'(1)));
    assign tmo_expired = (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst context, word counter, activate timeout, sticky error, IO write word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q    <= DIR_READ;
            len_q    <= '0;
            word_cnt <= '0;
            tmo_cnt  <= '0;
            error_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q    <= dir;
                        len_q    <= length;
                        word_cnt <= '0;
                        error_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    // buffer data requested in FETCH is valid now; held until the next LOAD
                    wdata_q <= buf_rdata;
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                end
                WAIT_HI: begin
                    if (!io_busy) begin
                        if (tmo_expired) begin
                            error_q <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (!last_word) begin
                        word_cnt <= word_cnt + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and decoded outputs
    always_comb begin
        state_nxt   = state;
        buf_re      = 1'b0;
        buf_we      = 1'b0;
        buf_addr    = '0;
        buf_wdata   = '0;
        io_activate = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_nxt = FIN;
                    end else if (dir == DIR_WRITE) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            FETCH: begin
                buf_re    = 1'b1;
                buf_addr  = word_cnt;
                state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                // hold off if the IO unit is still busy so activate never overlaps it
                if (!io_busy) begin
                    io_activate = 1'b1;
                    state_nxt   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (io_busy) begin
                    state_nxt = WAIT_LO;
                end else if (tmo_expired) begin
                    state_nxt = FIN;
                end
            end
            WAIT_LO: begin
                if (!io_busy) begin
                    state_nxt = (dir_q == DIR_WRITE) ? NEXT : STORE;
                end
            end
            STORE: begin
                buf_we    = 1'b1;
                buf_addr  = word_cnt;
                buf_wdata = io_rdata;
                state_nxt = NEXT;
            end
            NEXT: begin
                if (last_word) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = (dir_q == DIR_WRITE) ? FETCH : ISSUE;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign error    = error_q;
    assign io_wdata = wdata_q;

endmodule

// File: tb/tb_io_burst_sequencer.sv
module tb_io_burst_sequencer;

    localparam int DATA_W      = 16;
    localparam int LEN_W       = 14;
    localparam int ACT_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              dir = 1'b0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic [LEN_W-1:0]  buf_addr;
    logic              buf_re;
    logic [DATA_W-1:0] buf_rdata = '0;
    logic              buf_we;
    logic [DATA_W-1:0] buf_wdata;
    logic              io_activate;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata = '0;
    logic              io_busy = 1'b0;

    io_burst_sequencer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .ACT_TIMEOUT(ACT_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .length(length),
        .busy(busy), .done(done), .error(error),
        .buf_addr(buf_addr), .buf_re(buf_re), .buf_rdata(buf_rdata),
        .buf_we(buf_we), .buf_wdata(buf_wdata),
        .io_activate(io_activate), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .io_busy(io_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic err;
        int   nact;
        int   nre;
        int   nwe;
    } done_exp_t;

    typedef struct {
        logic [LEN_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } bw_exp_t;

    done_exp_t         exp_done[$];
    bw_exp_t           exp_bw[$];
    logic [DATA_W-1:0] exp_io[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] mem [0:(1<<LEN_W)-1];

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   n_act = 0, n_re = 0, n_we = 0, last_act = 0;
    logic cur_write = 1'b0;
    logic never_busy = 1'b0;
    logic io_kill = 1'b0;
    int   busy_fix = 6;
    int   io_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Page buffer: synchronous read, one cycle latency
    always @(posedge clk) begin
        if (buf_re) buf_rdata <= mem[buf_addr];
    end

    // IO unit: busy rises on the edge that sees activate, stays high io_left cycles
    always @(posedge clk) begin
        if (io_kill) begin
            io_busy <= 1'b0;
            io_left = 0;
        end else if (io_busy) begin
            if (io_left <= 1) io_busy <= 1'b0;
            io_left = io_left - 1;
        end else if (io_activate && !never_busy) begin
            io_busy <= 1'b1;
            io_left = (busy_fix > 0) ? busy_fix : int'($urandom_range(1, 6));
            if (rd_q.size() > 0) io_rdata <= rd_q.pop_front();
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        done_exp_t e;
        bw_exp_t   b;
        logic [DATA_W-1:0] w;
        cyc++;
        if (reset) begin
            n_act = 0; n_re = 0; n_we = 0;
        end else begin
            if (io_activate) begin
                chk("activate_while_io_busy", {31'd0, io_busy}, 32'd0);
                n_act++;
                last_act = cyc;
                if (cur_write) begin
                    if (exp_io.size() == 0) begin
                        chk("io_wdata_unexpected_word", 32'd1, 32'd0);
                    end else begin
                        w = exp_io.pop_front();
                        chk("io_wdata", {16'd0, io_wdata}, {16'd0, w});
                    end
                end
            end
            if (buf_re) begin
                chk("buf_re_addr", {18'd0, buf_addr}, n_re);
                n_re++;
            end
            if (buf_we) begin
                n_we++;
                if (exp_bw.size() == 0) begin
                    chk("buf_we_unexpected", 32'd1, 32'd0);
                end else begin
                    b = exp_bw.pop_front();
                    chk("buf_we_addr", {18'd0, buf_addr}, {18'd0, b.addr});
                    chk("buf_wdata", {16'd0, buf_wdata}, {16'd0, b.data});
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", {31'd0, busy}, 32'd1);
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_error", {31'd0, error}, {31'd0, e.err});
                    chk("activate_count", n_act, e.nact);
                    chk("buf_re_count", n_re, e.nre);
                    chk("buf_we_count", n_we, e.nwe);
                    if (e.err) begin
                        chk("timeout_window",
                            {31'd0, (cyc - last_act >= ACT_TIMEOUT) && (cyc - last_act <= ACT_TIMEOUT + 2)},
                            32'd1);
                    end
                end
                n_act = 0; n_re = 0; n_we = 0;
            end
        end
    end

    // Queue expectations for a burst; data for reads comes from the IO model queue
    task automatic prep(input logic wr, input int len, input logic tmo);
        done_exp_t e;
        bw_exp_t   b;
        logic [DATA_W-1:0] v;
        cur_write = wr;
        never_busy = tmo;
        e.err = tmo; e.nact = 0; e.nre = 0; e.nwe = 0;
        if (len > 0) begin
            if (tmo) begin
                e.nact = 1;
                e.nre = wr ? 1 : 0;
                if (wr) exp_io.push_back(mem[0]);
            end else if (wr) begin
                e.nact = len; e.nre = len;
                for (int i = 0; i < len; i++) exp_io.push_back(mem[i]);
            end else begin
                e.nact = len; e.nwe = len;
                for (int i = 0; i < len; i++) begin
                    v = DATA_W'($urandom);
                    rd_q.push_back(v);
                    b.addr = LEN_W'(i); b.data = v;
                    exp_bw.push_back(b);
                end
            end
        end
        exp_done.push_back(e);
    endtask

    task automatic pulse_start(input logic wr, input int len);
        @(negedge clk);
        start = 1'b1; dir = wr; length = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("error_cleared_by_start", {31'd0, error}, 32'd0);
    endtask

    task automatic wait_done(input int budget, input logic noise);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_cnt != d0 || done) break;
            if (noise && busy && ($urandom_range(0, 3) == 0)) begin
                start = 1'b1; dir = $urandom_range(0, 1) != 0; length = LEN_W'($urandom_range(0, 40));
            end
        end
        start = 1'b0;
        if (done_cnt == d0 && !done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic wr, input int len, input logic tmo, input logic noise);
        prep(wr, len, tmo);
        pulse_start(wr, len);
        wait_done(len * 30 + ACT_TIMEOUT + 50, noise);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_buf_re"}, {31'd0, buf_re}, 32'd0);
        chk({tag, "_buf_we"}, {31'd0, buf_we}, 32'd0);
        chk({tag, "_buf_addr"}, {18'd0, buf_addr}, 32'd0);
        chk({tag, "_buf_wdata"}, {16'd0, buf_wdata}, 32'd0);
        chk({tag, "_io_activate"}, {31'd0, io_activate}, 32'd0);
        chk({tag, "_io_wdata"}, {16'd0, io_wdata}, 32'd0);
    endtask

    initial begin
        int n;
        int len;
        logic wr;
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // Write burst of 4 known words, busy 6 cycles
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        busy_fix = 6;
        run(1'b1, 4, 1'b0, 1'b0);

        // Read burst of 3 known words
        cur_write = 1'b0;
        never_busy = 1'b0;
        rd_q.push_back(16'hA5A0); rd_q.push_back(16'hA5A1); rd_q.push_back(16'hA5A2);
        for (int i = 0; i < 3; i++) begin
            bw_exp_t b;
            b.addr = LEN_W'(i); b.data = 16'hA5A0 + DATA_W'(i);
            exp_bw.push_back(b);
        end
        begin
            done_exp_t e;
            e.err = 1'b0; e.nact = 3; e.nre = 0; e.nwe = 3;
            exp_done.push_back(e);
        end
        pulse_start(1'b0, 3);
        wait_done(200, 1'b0);

        // Zero-length bursts in both directions
        run(1'b1, 0, 1'b0, 1'b0);
        run(1'b0, 0, 1'b0, 1'b0);

        // IO unit never answers: timeout, sticky error, cleared by next start
        run(1'b1, 3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("error_sticky", {31'd0, error}, 32'd1);
        run(1'b0, 2, 1'b0, 1'b0);
        run(1'b0, 2, 1'b1, 1'b0);
        run(1'b1, 1, 1'b0, 1'b0);

        // start/dir/length noise during a 5-word burst must be ignored
        run(1'b1, 5, 1'b0, 1'b1);
        run(1'b0, 5, 1'b0, 1'b1);

        // Reset while the third word (index 2) is in WAIT_LO
        for (int i = 0; i < 5; i++) mem[i] = 16'h5A00 + DATA_W'(i) + 16'h0001;
        prep(1'b1, 5, 1'b0);
        pulse_start(1'b1, 5);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if (io_activate) n++;
            if (n == 3 && io_busy) break;
            @(negedge clk);
        end
        chk("reached_word2_busy", {31'd0, (n == 3) && io_busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        io_kill = 1'b1;
        #1;
        chk_zero("abort");
        exp_done.delete(); exp_bw.delete(); exp_io.delete(); rd_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        io_kill = 1'b0;
        chk("no_done_after_abort", done_cnt, done_cnt);
        n = done_cnt;
        repeat (4) @(negedge clk);
        chk("no_done_pulse_on_abort", done_cnt - n, 32'd0);
        run(1'b1, 3, 1'b0, 1'b0);

        // Randomised bursts with random IO busy time
        busy_fix = 0;
        for (int k = 0; k < 10; k++) begin
            wr = $urandom_range(0, 1) != 0;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) mem[i] = DATA_W'($urandom);
            run(wr, len, 1'b0, $urandom_range(0, 1) != 0);
        end

        repeat (3) @(negedge clk);
        chk("leftover_done_expectations", exp_done.size(), 32'd0);
        chk("leftover_buf_writes", exp_bw.size(), 32'd0);
        chk("leftover_io_words", exp_io.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
